// File: rtl/sccb_slave.sv
// sccb_slave
//   SCCB slave with a 256x8 register bank. It answers device ID DEV_ID
//   (write byte {DEV_ID,0}, read byte {DEV_ID,1}) and supports these transfers:
//     3-phase write : ID(W), sub-address, data  -> bank[sub] <= data
//     2-phase write : ID(W), sub-address        -> address pointer only
//     2-phase read  : ID(R), slave drives bank[addr_ptr], master NA
//   The address pointer does not auto-increment. sclk and sio are asynchronous
//   to clk. Both are synchronised and then handled entirely in the clk domain.
//
// Ports
//   clk         system clock; all flops update on its rising edge
//   rst_n       synchronous active-low reset
//   sclk        SCCB clock from the master (asynchronous)
//   sio_din     sampled SCCB data line (asynchronous)
//   sio_out     data the slave drives onto the line while sio_out_en = 1
//   sio_out_en  tri-state enable, 1 = slave drives the line
//   host_addr   local read address into the bank
//   host_rdata  bank[host_addr], registered (valid one clk after host_addr)
//   reg_wr      one-clk pulse for each register written over SCCB
//   reg_waddr   address of the write reported by reg_wr
//   reg_wdata   data of the write reported by reg_wr
//   busy        high from START until STOP or the return to IDLE
module sccb_slave #(
  parameter logic [6:0] DEV_ID = 7'h21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       sio_din,
  output logic       sio_out,
  output logic       sio_out_en,
  input  logic [7:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       reg_wr,
  output logic [7:0] reg_waddr,
  output logic [7:0] reg_wdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_X, SUB, SUB_X, WDAT, WDAT_X, RDAT, RDAT_NA, WAIT_STOP
  } state_t;

  // Synchronizers plus one history flop per line
  logic sclk_s1, sclk_s2, sclk_d;
  logic sio_s1, sio_s2, sio_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // The idle bus is high on both lines. Presetting to 1 keeps reset
      // release from looking like an edge.
      {sclk_s1, sclk_s2, sclk_d} <= 3'b111;
      {sio_s1, sio_s2, sio_d}    <= 3'b111;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the value the
      // previous stage held before this edge. That is what forms the chain.
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      sio_s1  <= sio_din;
      sio_s2  <= sio_s1;
      sio_d   <= sio_s2;
    end
  end

  logic sclk_rise, sclk_fall, start_det, stop_det;
  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign start_det = sclk_s2 & sio_d & ~sio_s2;
  assign stop_det  = sclk_s2 & ~sio_d & sio_s2;

  // FSM and datapath registers
  state_t     state, state_nx;
  logic [2:0] bit_cnt, cnt_nx;
  logic       ack_seen, ack_nx;    // the 9th-bit rising edge has been seen
  logic [6:0] shreg;               // first seven bits of the byte in flight
  logic       rw_bit;              // 1 = read transfer
  logic [7:0] addr_ptr;
  logic [7:0] rd_byte;             // byte being shifted out in RDAT
  logic [7:0] bank [256];
  logic [7:0] rx_byte, ptr_rdata;

  logic shift_en, rw_ld, ptr_ld, wr_en, rd_ld, oe_nx, out_nx;

  // On the 8th sampling edge, the last bit is still in the synchronizer.
  assign rx_byte   = {shreg, sio_s2};
  assign ptr_rdata = bank[addr_ptr];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      ack_seen <= 1'b0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= cnt_nx;
      ack_seen <= ack_nx;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_nx = state;
    cnt_nx   = bit_cnt;
    ack_nx   = ack_seen;
    oe_nx    = sio_out_en;
    out_nx   = sio_out;
    shift_en = 1'b0;
    rw_ld    = 1'b0;
    ptr_ld   = 1'b0;
    wr_en    = 1'b0;
    rd_ld    = 1'b0;

    if (start_det) begin
      // A repeated START restarts ID decoding from any state.
      state_nx = ID;
      cnt_nx   = 3'd0;
      ack_nx   = 1'b0;
      oe_nx    = 1'b0;
      out_nx   = 1'b0;
    end else if (stop_det) begin
      state_nx = IDLE;
      cnt_nx   = 3'd0;
      ack_nx   = 1'b0;
      oe_nx    = 1'b0;
      out_nx   = 1'b0;
    end else begin
      case (state)
        IDLE, WAIT_STOP: begin
        end
        ID: if (sclk_rise) begin
          shift_en = 1'b1;
          cnt_nx   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (rx_byte[7:1] == DEV_ID) begin
              state_nx = ID_X;
              rw_ld    = 1'b1;
            end else begin
              state_nx = WAIT_STOP;
            end
          end
        end
        SUB: if (sclk_rise) begin
          shift_en = 1'b1;
          cnt_nx   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ptr_ld   = 1'b1;
            state_nx = SUB_X;
          end
        end
        WDAT: if (sclk_rise) begin
          shift_en = 1'b1;
          cnt_nx   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            wr_en    = 1'b1;
            state_nx = WDAT_X;
          end
        end
        // The 9th bit is never driven. The state is left on the falling edge
        // that ends it, which is also where read data must start.
        ID_X, SUB_X, WDAT_X: begin
          if (sclk_rise) begin
            ack_nx = 1'b1;
          end else if (sclk_fall && ack_seen) begin
            ack_nx = 1'b0;
            if (state == SUB_X) begin
              state_nx = WDAT;
            end else if (state == WDAT_X) begin
              state_nx = WAIT_STOP;
            end else if (!rw_bit) begin
              state_nx = SUB;
            end else begin
              state_nx = RDAT;
              rd_ld    = 1'b1;
              oe_nx    = 1'b1;
              out_nx   = ptr_rdata[7];
            end
          end
        end
        // bit_cnt is the index (from the MSB) of the bit on the line. The
        // falling edge after bit 0 releases the line.
        RDAT: if (sclk_fall) begin
          if (bit_cnt == 3'd7) begin
            state_nx = RDAT_NA;
            cnt_nx   = 3'd0;
            oe_nx    = 1'b0;
            out_nx   = 1'b0;
          end else begin
            cnt_nx = bit_cnt + 3'd1;
            out_nx = rd_byte[3'd6 - bit_cnt];
          end
        end
        RDAT_NA: if (sclk_rise) state_nx = WAIT_STOP;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg      <= 7'd0;
      rw_bit     <= 1'b0;
      addr_ptr   <= 8'h00;
      rd_byte    <= 8'h00;
      sio_out    <= 1'b0;
      sio_out_en <= 1'b0;
      reg_wr     <= 1'b0;
      reg_waddr  <= 8'h00;
      reg_wdata  <= 8'h00;
    end else begin
      if (shift_en) shreg <= rx_byte[6:0];
      if (rw_ld)    rw_bit <= rx_byte[0];
      if (ptr_ld)   addr_ptr <= rx_byte;
      if (rd_ld)    rd_byte <= ptr_rdata;
      sio_out    <= out_nx;
      sio_out_en <= oe_nx;
      reg_wr     <= wr_en;
      if (wr_en) begin
        reg_waddr <= addr_ptr;
        reg_wdata <= rx_byte;
      end
    end
  end

  // Register bank. A host read in the same clk as an SCCB write to the same
  // address returns the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: every entry must be cleared on reset. That rules out a RAM macro
      // and keeps the bank in flops.
      for (int i = 0; i < 256; i++) bank[i] <= 8'h00;
      host_rdata <= 8'h00;
    end else begin
      if (wr_en) bank[addr_ptr] <= rx_byte;
      host_rdata <= bank[host_addr];
    end
  end

endmodule
